// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types, AXI constants and geometry helpers for the refill arbiter.
// REFILL_ARB_CRITICAL_WORD_FIRST_EN selects critical-word-first WRAP bursts.
package refill_arb_pkg;

  typedef enum logic [1:0] {IDLE, AR, R, RSP} state_e;
  typedef enum logic {SRC_IC, SRC_DC} src_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic int calc_beats(input int line_w, input int data_w);
    return line_w / data_w;
  endfunction

  function automatic int calc_line_off(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int calc_size(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/refill_line_asm.sv
// Beat counter, line buffer and error accumulation for one refill burst.
// REFILL_ARB_CRITICAL_WORD_FIRST_EN: wrapping start index, rlast must be the BEATS-th beat.
module refill_line_asm import refill_arb_pkg::*; #(
  parameter int LINE_WIDTH = 256,
  parameter int AXI_DATA_W = 32,
  localparam int BEATS = calc_beats(LINE_WIDTH, AXI_DATA_W),
  localparam int IDX_W = $clog2(BEATS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [IDX_W-1:0]      start_idx_i,
  input  logic                  beat_i,
  input  logic [AXI_DATA_W-1:0] data_i,
  input  logic                  resp_err_i,
  input  logic                  last_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  err_o
);

  logic [IDX_W-1:0] cnt_reg;
  logic             err_reg;
  logic             wr_en;
  logic             last_ok;

`ifdef REFILL_ARB_CRITICAL_WORD_FIRST_EN
  // Received-beat count, saturating at BEATS; the write index wraps on its own.
  logic [IDX_W:0] rcv_reg;
  assign wr_en   = (rcv_reg < (IDX_W+1)'(BEATS));
  assign last_ok = (rcv_reg == (IDX_W+1)'(BEATS - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rcv_reg <= '0;
    end else if (start_i) begin
      rcv_reg <= '0;
    end else if (beat_i && wr_en) begin
      rcv_reg <= rcv_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (start_i) begin
      cnt_reg <= start_idx_i;
    end else if (beat_i) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  // full_reg marks that the last word has been written; cnt_reg saturates.
  logic full_reg;
  assign wr_en   = !full_reg;
  assign last_ok = (cnt_reg == IDX_W'(BEATS - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_reg  <= '0;
      full_reg <= 1'b0;
    end else if (start_i) begin
      cnt_reg  <= start_idx_i;
      full_reg <= 1'b0;
    end else if (beat_i) begin
      if (cnt_reg == IDX_W'(BEATS - 1)) begin
        full_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_reg <= 1'b0;
    end else if (start_i) begin
      err_reg <= 1'b0;
    end else if (beat_i && (resp_err_i || (last_i && !last_ok))) begin
      err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
    logic [AXI_DATA_W-1:0] word_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        word_reg <= '0;
      end else if (beat_i && wr_en && (cnt_reg == IDX_W'(gi))) begin
        word_reg <= data_i;
      end
    end
    assign line_o[gi*AXI_DATA_W +: AXI_DATA_W] = word_reg;
  end

  assign err_o = err_reg;

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin ICache/DCache line-refill arbiter over one AXI4 read channel.
// REFILL_ARB_CRITICAL_WORD_FIRST_EN switches to word-aligned WRAP bursts.
module mem_refill_arbiter import refill_arb_pkg::*; #(
  parameter int LINE_WIDTH = 256,
  parameter int AXI_DATA_W = 32,
  parameter int ADDR_W     = 32,
  parameter int MSHR_ID_W  = 2,
  parameter int AXI_ID_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ic_req_valid_i,
  output logic                  ic_req_ready_o,
  input  logic [ADDR_W-1:0]     ic_req_addr_i,
  output logic                  ic_rsp_valid_o,
  output logic                  ic_rsp_err_o,
  output logic [LINE_WIDTH-1:0] ic_rsp_data_o,
  input  logic                  dc_req_valid_i,
  output logic                  dc_req_ready_o,
  input  logic [ADDR_W-1:0]     dc_req_addr_i,
  input  logic [MSHR_ID_W-1:0]  dc_req_id_i,
  output logic                  dc_rsp_valid_o,
  output logic                  dc_rsp_err_o,
  output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
  output logic [MSHR_ID_W-1:0]  dc_rsp_id_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [ADDR_W-1:0]     m_araddr_o,
  output logic [7:0]            m_arlen_o,
  output logic [2:0]            m_arsize_o,
  output logic [1:0]            m_arburst_o,
  output logic [AXI_ID_W-1:0]   m_arid_o,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [AXI_DATA_W-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rlast_i,
  input  logic [AXI_ID_W-1:0]   m_rid_i
);

  localparam int BEATS    = calc_beats(LINE_WIDTH, AXI_DATA_W);
  localparam int LINE_OFF = calc_line_off(LINE_WIDTH);
  localparam int SIZE     = calc_size(AXI_DATA_W);
  localparam int IDX_W    = $clog2(BEATS);

  state_e                state_reg, state_next;
  logic                  rr_reg;
  src_e                  src_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [MSHR_ID_W-1:0]  id_reg;
  logic                  grant_ic, grant_dc;
  logic [IDX_W-1:0]      start_idx;
  logic [LINE_WIDTH-1:0] line;
  logic                  line_err;
  logic                  unused_bits;

  // rr_reg=1 favours DCache when both requesters are waiting.
  assign grant_dc = dc_req_valid_i && (!ic_req_valid_i || rr_reg);
  assign grant_ic = ic_req_valid_i && !grant_dc;

  always_comb begin
    state_next     = state_reg;
    ic_req_ready_o = 1'b0;
    dc_req_ready_o = 1'b0;
    m_arvalid_o    = 1'b0;
    m_rready_o     = 1'b0;
    ic_rsp_valid_o = 1'b0;
    dc_rsp_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        ic_req_ready_o = grant_ic;
        dc_req_ready_o = grant_dc;
        if (grant_ic || grant_dc) state_next = AR;
      end
      AR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) state_next = R;
      end
      R: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i && m_rlast_i) state_next = RSP;
      end
      RSP: begin
        ic_rsp_valid_o = (src_reg == SRC_IC);
        dc_rsp_valid_o = (src_reg == SRC_DC);
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      rr_reg    <= 1'b1;
      src_reg   <= SRC_IC;
      addr_reg  <= '0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_dc) begin
        src_reg  <= SRC_DC;
        addr_reg <= dc_req_addr_i;
        id_reg   <= dc_req_id_i;
        rr_reg   <= 1'b0;
      end else if (state_reg == IDLE && grant_ic) begin
        src_reg  <= SRC_IC;
        addr_reg <= ic_req_addr_i;
        rr_reg   <= 1'b1;
      end
    end
  end

`ifdef REFILL_ARB_CRITICAL_WORD_FIRST_EN
  assign m_araddr_o  = addr_reg & ~((ADDR_W'(1) << SIZE) - ADDR_W'(1));
  assign m_arburst_o = AXI_BURST_WRAP;
  assign start_idx   = addr_reg[LINE_OFF-1:SIZE];
`else
  assign m_araddr_o  = addr_reg & ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));
  assign m_arburst_o = AXI_BURST_INCR;
  assign start_idx   = '0;
`endif

  assign m_arlen_o  = 8'(BEATS - 1);
  assign m_arsize_o = 3'(SIZE);
  assign m_arid_o   = (src_reg == SRC_DC) ? AXI_ID_W'(1) : '0;

  refill_line_asm #(
    .LINE_WIDTH (LINE_WIDTH),
    .AXI_DATA_W (AXI_DATA_W)
  ) u_line_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (state_reg == AR && m_arready_i),
    .start_idx_i (start_idx),
    .beat_i      (state_reg == R && m_rvalid_i),
    .data_i      (m_rdata_i),
    .resp_err_i  (m_rresp_i[1]),
    .last_i      (m_rlast_i),
    .line_o      (line),
    .err_o       (line_err)
  );

  assign ic_rsp_data_o = line;
  assign dc_rsp_data_o = line;
  assign ic_rsp_err_o  = line_err;
  assign dc_rsp_err_o  = line_err;
  assign dc_rsp_id_o   = id_reg;

  // Only one burst is ever in flight, so RID and the OKAY/EXOKAY bit carry no information.
  assign unused_bits = ^{m_rid_i, m_rresp_i[0]};

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomized bench for mem_refill_arbiter against a transaction-level model.
// Honours REFILL_ARB_CRITICAL_WORD_FIRST_EN when defined.
module tb_mem_refill_arbiter;

  localparam int LW    = 256;
  localparam int DW    = 32;
  localparam int BEATS = LW / DW;
`ifdef REFILL_ARB_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ic_req_valid_i = 1'b0, ic_req_ready_o;
  logic [31:0]   ic_req_addr_i = '0;
  logic          ic_rsp_valid_o, ic_rsp_err_o;
  logic [LW-1:0] ic_rsp_data_o;
  logic          dc_req_valid_i = 1'b0, dc_req_ready_o;
  logic [31:0]   dc_req_addr_i = '0;
  logic [1:0]    dc_req_id_i = '0;
  logic          dc_rsp_valid_o, dc_rsp_err_o;
  logic [LW-1:0] dc_rsp_data_o;
  logic [1:0]    dc_rsp_id_o;
  logic          m_arvalid_o, m_arready_i = 1'b0;
  logic [31:0]   m_araddr_o;
  logic [7:0]    m_arlen_o;
  logic [2:0]    m_arsize_o;
  logic [1:0]    m_arburst_o;
  logic [3:0]    m_arid_o;
  logic          m_rvalid_i = 1'b0, m_rready_o;
  logic [DW-1:0] m_rdata_i = '0;
  logic [1:0]    m_rresp_i = '0;
  logic          m_rlast_i = 1'b0;
  logic [3:0]    m_rid_i = '0;

  mem_refill_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_req_addr_i(ic_req_addr_i),
    .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_err_o(ic_rsp_err_o), .ic_rsp_data_o(ic_rsp_data_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_id_i(dc_req_id_i), .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_err_o(dc_rsp_err_o),
    .dc_rsp_data_o(dc_rsp_data_o), .dc_rsp_id_o(dc_rsp_id_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arid_o(m_arid_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i), .m_rid_i(m_rid_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: priority flag, pending requests, and the line as an array of words
  bit          rr_m = 1'b1;
  bit          ic_pend = 1'b0, dc_pend = 1'b0;
  logic [31:0] ic_addr_m = '0, dc_addr_m = '0;
  logic [1:0]  dc_id_m = '0;
  logic [31:0] line_m [BEATS];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] packed_line();
    logic [LW-1:0] v;
    for (int i = 0; i < BEATS; i++) v[i*DW +: DW] = line_m[i];
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, m_arvalid_o, 1'b0);
    check({tag, "_rready"}, m_rready_o, 1'b0);
    check({tag, "_ic_rsp_valid"}, ic_rsp_valid_o, 1'b0);
    check({tag, "_dc_rsp_valid"}, dc_rsp_valid_o, 1'b0);
    check({tag, "_rsp_data"}, dc_rsp_data_o, '0);
    check({tag, "_rsp_err"}, ic_rsp_err_o, 1'b0);
    check({tag, "_rsp_id"}, dc_rsp_id_o, 2'd0);
  endtask

  // err_beat: -1 no error, -2 random errors, >=0 force SLVERR on that beat.
  // abort_beat >= 0 resets the DUT just before that beat would be driven.
  task automatic run_txn(input bit new_ic, input bit new_dc, input logic [31:0] a_ic,
                         input logic [31:0] a_dc, input logic [1:0] id_dc, input int ar_wait,
                         input int gap_max, input int nbeats, input bit seq_data,
                         input int err_beat, input int abort_beat);
    bit          exp_dc, err_m;
    logic [31:0] addr, exp_araddr, d;
    logic [1:0]  rsp;
    int          start;
    if (new_ic && !ic_pend) begin ic_pend = 1'b1; ic_addr_m = a_ic; end
    if (new_dc && !dc_pend) begin dc_pend = 1'b1; dc_addr_m = a_dc; dc_id_m = id_dc; end
    if (!ic_pend && !dc_pend) begin ic_pend = 1'b1; ic_addr_m = a_ic; end
    exp_dc = dc_pend && (!ic_pend || rr_m);

    @(negedge clk);
    ic_req_valid_i = ic_pend; ic_req_addr_i = ic_addr_m;
    dc_req_valid_i = dc_pend; dc_req_addr_i = dc_addr_m; dc_req_id_i = dc_id_m;
    #1;
    check("ic_ready", ic_req_ready_o, ic_pend && !exp_dc);
    check("dc_ready", dc_req_ready_o, exp_dc);
    check("idle_rsp_valid", {ic_rsp_valid_o, dc_rsp_valid_o}, 2'b00);

    addr = exp_dc ? dc_addr_m : ic_addr_m;
    if (exp_dc) dc_pend = 1'b0; else ic_pend = 1'b0;
    rr_m = !exp_dc;
    exp_araddr = CWF ? (addr & ~32'h3) : (addr & ~32'h1F);
    start = CWF ? int'(addr[4:2]) : 0;

    for (int c = 0; c <= ar_wait; c++) begin
      @(negedge clk);
      ic_req_valid_i = ic_pend; dc_req_valid_i = dc_pend;
      m_arready_i = (c == ar_wait);
      #1;
      check("arvalid", m_arvalid_o, 1'b1);
      check("araddr", m_araddr_o, exp_araddr);
      check("arlen", m_arlen_o, 8'd7);
      check("arsize", m_arsize_o, 3'd2);
      check("arburst", m_arburst_o, CWF ? 2'b10 : 2'b01);
      check("arid", m_arid_o, exp_dc ? 4'd1 : 4'd0);
      check("busy_ready", {ic_req_ready_o, dc_req_ready_o}, 2'b00);
    end

    err_m = (nbeats != BEATS);
    for (int k = 0; k < nbeats; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk);
        m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
        #1 check("rready_gap", m_rready_o, 1'b1);
      end
      @(negedge clk);
      m_arready_i = 1'b0;
      if (k == abort_beat) begin
        rst_ni = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
        ic_req_valid_i = 1'b0; dc_req_valid_i = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("abort");
        rst_ni = 1'b1;
        rr_m = 1'b1; ic_pend = 1'b0; dc_pend = 1'b0;
        for (int i = 0; i < BEATS; i++) line_m[i] = '0;
        return;
      end
      d = seq_data ? 32'(k) : $urandom;
      if (err_beat == -2) rsp = {($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1))};
      else rsp = (k == err_beat) ? 2'b10 : 2'b00;
      m_rvalid_i = 1'b1; m_rdata_i = d; m_rresp_i = rsp; m_rlast_i = (k == nbeats - 1);
      #1 check("rready_beat", m_rready_o, 1'b1);
      if (rsp[1]) err_m = 1'b1;
      if (k < BEATS) line_m[(start + k) % BEATS] = d;
    end

    @(negedge clk);
    m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_rresp_i = 2'b00;
    #1;
    check("ic_rsp_valid", ic_rsp_valid_o, !exp_dc);
    check("dc_rsp_valid", dc_rsp_valid_o, exp_dc);
    if (exp_dc) begin
      check("dc_rsp_data", dc_rsp_data_o, packed_line());
      check("dc_rsp_err", dc_rsp_err_o, err_m);
      check("dc_rsp_id", dc_rsp_id_o, dc_id_m);
      $display("txn DC addr=%08h id=%0d beats=%0d err=%0d", addr, dc_id_m, nbeats, err_m);
    end else begin
      check("ic_rsp_data", ic_rsp_data_o, packed_line());
      check("ic_rsp_err", ic_rsp_err_o, err_m);
      $display("txn IC addr=%08h beats=%0d err=%0d", addr, nbeats, err_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < BEATS; i++) line_m[i] = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    check("reset_ready", {ic_req_ready_o, dc_req_ready_o}, 2'b00);
    rst_ni = 1'b1;

    // Directed scenarios
    run_txn(1, 0, 32'h8000_0044, 32'h0, 2'd0, 0, 0, 8, 1, -1, -1);
    run_txn(1, 1, 32'h0000_1230, 32'h0000_2468, 2'd2, 0, 0, 8, 0, -1, -1);
    run_txn(0, 1, 32'h0, 32'h0000_3000, 2'd1, 0, 0, 8, 0, -1, -1);
    run_txn(0, 0, 32'h0000_4000, 32'h0, 2'd0, 0, 0, 8, 0, -1, -1);
    run_txn(0, 1, 32'h0, 32'h0000_5040, 2'd3, 0, 0, 8, 0, 3, -1);
    run_txn(1, 0, 32'h0000_6000, 32'h0, 2'd0, 0, 0, 5, 0, -1, -1);
    run_txn(1, 0, 32'h0000_6080, 32'h0, 2'd0, 0, 0, 8, 0, -1, -1);
    run_txn(0, 1, 32'h0, 32'h0000_7100, 2'd1, 4, 3, 8, 0, -1, -1);
    run_txn(1, 0, 32'h0000_100C, 32'h0, 2'd0, 0, 0, 8, 1, -1, -1);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 2),
              ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8, 0, -2, -1);
    end

    // Reset in the middle of a burst, then normal traffic resumes
    run_txn(1, 1, 32'h0000_9000, 32'h0000_A000, 2'd2, 1, 1, 8, 0, -1, 3);
    for (int t = 0; t < 4; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2), 8, 0, -2, -1);
    end

    @(negedge clk); #1;
    check("final_rsp_valid", {ic_rsp_valid_o, dc_rsp_valid_o}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares a single AXI4 read channel between ICache line refill and DCache MSHR line refill.
- Grants one requester at a time by round-robin and issues one INCR burst per line.
- Assembles the returned beats into one cache line and returns it to the granted requester with the request tag.
- Sits between the ICache/DCache miss logic and the top-level AXI crossbar; one transaction outstanding at a time.

Parameters:
- LINE_WIDTH, 256, cache line bits (ICache and DCache share the line width).
- AXI_DATA_W, 32, AXI data bus bits.
- ADDR_W, 32, address bits.
- MSHR_ID_W, 2, DCache MSHR tag bits (log2 of DCACHE_MSHR_SIZE=4).
- AXI_ID_W, 4, AXI ID bits.
- Derived: BEATS = LINE_WIDTH/AXI_DATA_W (8); LINE_OFF = log2(LINE_WIDTH/8) (5); SIZE = log2(AXI_DATA_W/8) (2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- ic_req_valid_i  in  1  ICache refill request
- ic_req_ready_o  out  1  request accepted this cycle
- ic_req_addr_i  in  ADDR_W  miss address
- ic_rsp_valid_o  out  1  one-cycle line-return pulse
- ic_rsp_err_o  out  1  bus error, valid with ic_rsp_valid_o
- ic_rsp_data_o  out  LINE_WIDTH  line data
- dc_req_valid_i / dc_req_ready_o / dc_req_addr_i  in/out/in  1/1/ADDR_W  DCache refill handshake and address
- dc_req_id_i  in  MSHR_ID_W  MSHR tag
- dc_rsp_valid_o / dc_rsp_err_o  out  1/1  return pulse and error
- dc_rsp_data_o  out  LINE_WIDTH  line data
- dc_rsp_id_o  out  MSHR_ID_W  echoed tag
- m_arvalid_o / m_arready_i  out/in  1/1  AR handshake
- m_araddr_o  out  ADDR_W  burst address
- m_arlen_o  out  8  burst length
- m_arsize_o  out  3  beat size
- m_arburst_o  out  2  burst type
- m_arid_o  out  AXI_ID_W  burst ID
- m_rvalid_i / m_rready_o  in/out  1/1  R handshake
- m_rdata_i  in  AXI_DATA_W  beat data
- m_rresp_i  in  2  beat response
- m_rlast_i  in  1  last beat
- m_rid_i  in  AXI_ID_W  beat ID (ignored; single outstanding)

Behaviour:
- One clock, clk_i; reset synchronous, active-low on rst_ni. FSM states IDLE -> AR -> R -> RSP -> IDLE.
- Reset values: state=IDLE; all *_valid_o, *_ready_o, m_arvalid_o, m_rready_o = 0; rsp data/id/err = 0; rr_q = 1 (DCache has priority first).
- IDLE, grant:
  - Both valid: rr_q=1 grants DCache, rr_q=0 grants ICache.
  - Only one valid: that requester is granted.
  - Granted requester's req_ready_o=1 combinationally, only in IDLE.
  - On accept, latch source, addr and id; rr_q points to the other source; go to AR.
- AR:
  - m_arvalid_o=1; araddr = addr with low LINE_OFF bits cleared; arlen = BEATS-1 (7); arsize = SIZE (2); arburst = INCR (2'b01); arid = 0 for ICache, 1 for DCache.
  - Fields stay stable until m_arready_i. On the handshake, go to R, with beat counter = 0 and err = 0.
- R:
  - m_rready_o=1. Each beat writes line[cnt*AXI_DATA_W +: AXI_DATA_W]; cnt increments and saturates at BEATS-1. Beats past the last index are accepted but not written.
  - err is set sticky on m_rresp_i[1]=1 (SLVERR/DECERR).
  - On the rlast beat: if cnt != BEATS-1, set err. Go to RSP.
- RSP: the source's rsp_valid_o pulses for exactly 1 cycle with line, err, and id (DCache); then go to IDLE. The line buffer keeps its value until the next burst.
- Latency with a zero-wait slave:
  - accept at cycle 0, arvalid at cycle 1, beats at cycles 2–9, rsp_valid at cycle 10.
  - A new request can be accepted at cycle 11 (the IDLE cycle).
- Requests arriving outside IDLE stay pending (ready=0); requesters must hold valid and address stable.
- Reset mid-burst returns to IDLE with all outputs at reset values. The outstanding AXI burst is abandoned; the system reset also resets the slave.

Optional Feature:
- Macro: REFILL_ARB_CRITICAL_WORD_FIRST_EN.
- Defined: araddr = request address aligned to AXI_DATA_W/8 only; arburst = WRAP (2'b10); cnt starts at addr[LINE_OFF-1:SIZE] and wraps modulo BEATS, so the line is still placed in natural order. The rlast check becomes: the rlast beat must be the BEATS-th beat received.
- Undefined: line-aligned INCR as above.

Decomposition:
- Package refill_arb_pkg holds:
  - state_e {IDLE, AR, R, RSP}
  - src_e {SRC_IC, SRC_DC}
  - AXI_BURST_INCR / AXI_BURST_WRAP constants
  - AXI_RESP_* constants
  - BEATS/LINE_OFF helper functions computed from config_pkg user_cfg_t line-width fields
- Sub-module refill_line_asm: beat counter, line buffer, error accumulation, rlast check. The arbiter keeps the FSM and round-robin logic.

Test Plan:
- Single ICache request at addr 0x8000_0044, zero-wait slave with beats 0x0..0x7 -> araddr 0x8000_0040, arlen 7, arid 0; ic_rsp_valid at cycle 10; data word i = i; err 0.
- ICache and DCache requests in the same cycle, with DCache id=2, then both re-requesting -> grants DC, IC, DC in that order; dc_rsp_id_o=2.
- Beat 3 returns rresp=2'b10 -> dc_rsp_err_o=1 with the full burst consumed, then return to IDLE.
- rlast asserted on beat 5 -> rsp issued after beat 5 with err=1; a following request is processed normally.
- arready held low for 4 cycles, plus random rvalid gaps -> AR fields stable throughout; line is correct.
- With REFILL_ARB_CRITICAL_WORD_FIRST_EN, addr 0x100C -> araddr 0x100C, WRAP; the first beat lands in word 3; the line is in natural order.
